// File: rtl/instr_decoder_pkg.sv
// instr_decoder_pkg: opcode constants, FSM state and instruction word types
package instr_decoder_pkg;
   localparam logic [3:0] OP_LOAD = 4'b0000, OP_LOAD_MASK = 4'b1000;
   localparam logic [3:0] OP_MOVE = 4'b1000, OP_MOVE_MASK = 4'b1100;
   localparam logic [3:0] OP_ALU  = 4'b1100, OP_ALU_MASK  = 4'b1110;
   localparam logic [3:0] OP_JMP  = 4'b1110, OP_JMP_MASK  = 4'b1111;
   localparam logic [3:0] OP_JNZ  = 4'b1111, OP_JNZ_MASK  = 4'b1111;
   localparam int CLS_LOAD = 0, CLS_MOVE = 1, CLS_ALU = 2, CLS_JMP = 3, CLS_JNZ = 4;
   typedef enum logic {HOLD, RUN} dec_state_t;
   typedef struct packed {
      logic [3:0] op;
      logic [3:0] imm;
   } instr_t;
   function automatic logic op_match(input logic [3:0] op, input logic [3:0] val, input logic [3:0] mask);
      return (op & mask) == val;
   endfunction
endpackage

// File: rtl/instr_decoder_opcode_decode.sv
// opcode_decode: one-hot opcode class and operand nibble of an instruction word
module opcode_decode
   import instr_decoder_pkg::*;
(
   input  logic [7:0] pm_data,
   output logic [4:0] op_class,
   output logic [3:0] imm
);
   instr_t ins;
   assign ins = instr_t'(pm_data);
   assign imm = ins.imm;
   assign op_class[CLS_LOAD] = op_match(ins.op, OP_LOAD, OP_LOAD_MASK);
   assign op_class[CLS_MOVE] = op_match(ins.op, OP_MOVE, OP_MOVE_MASK);
   assign op_class[CLS_ALU]  = op_match(ins.op, OP_ALU, OP_ALU_MASK);
   assign op_class[CLS_JMP]  = op_match(ins.op, OP_JMP, OP_JMP_MASK);
   assign op_class[CLS_JNZ]  = op_match(ins.op, OP_JNZ, OP_JNZ_MASK);
endmodule

// File: rtl/instr_decoder.sv
// instr_decoder: drives program_sequencer controls, zero flag, reset window and jump squash
module instr_decoder
   import instr_decoder_pkg::*;
#(
   parameter int RESET_CYCLES  = 2,
   parameter bit FLUSH_ON_JUMP = 1'b1
)(
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] pm_data,
   input  logic       alu_zero,
   output logic       sync_reset,
   output logic       jmp,
   output logic       jmp_nz,
   output logic       dont_jmp,
   output logic [3:0] jmp_addr,
   output logic       alu_en,
   output logic       load_en,
   output logic       flush
);
   dec_state_t state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic [4:0] op_class;
   logic [3:0] imm;
   logic       z, valid, taken;

   opcode_decode u_opcode_decode (.pm_data(pm_data), .op_class(op_class), .imm(imm));

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state <= HOLD;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end

   always_comb begin
      cnt_nxt   = (state == HOLD) ? cnt + 4'd1 : cnt;
      state_nxt = (state == HOLD && cnt == 4'(RESET_CYCLES - 1)) ? RUN : state;
   end

   assign valid    = (state == RUN) && !sync_reset && !flush;
   assign jmp      = valid && op_class[CLS_JMP];
   assign jmp_nz   = valid && op_class[CLS_JNZ];
   assign alu_en   = valid && op_class[CLS_ALU];
   assign load_en  = valid && (op_class[CLS_LOAD] || op_class[CLS_MOVE]);
   assign jmp_addr = (jmp || jmp_nz) ? imm : 4'h0;
   assign taken    = jmp || (jmp_nz && !z);
   assign dont_jmp = z;

   // a flushed cycle is never valid, so it cannot re-arm flush
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         sync_reset <= 1'b1;
         z          <= 1'b0;
         flush      <= 1'b0;
      end else begin
         sync_reset <= (state_nxt == HOLD);
         z          <= sync_reset ? 1'b0 : (alu_en ? alu_zero : z);
         flush      <= FLUSH_ON_JUMP && taken;
      end
endmodule

// File: tb/tb_instr_decoder.sv
// tb_instr_decoder: table-driven scoreboard bench for instr_decoder
module tb_instr_decoder;
   logic clk = 1'b0, reset = 1'b0, alu_zero = 1'b0;
   logic [7:0] pm_data = 8'hE5;
   logic sync_reset, jmp, jmp_nz, dont_jmp, alu_en, load_en, flush;
   logic sync_reset_b, jmp_b, jmp_nz_b, dont_jmp_b, alu_en_b, load_en_b, flush_b;
   logic [3:0] jmp_addr, jmp_addr_b;
   logic [10:0] act;
   int n_chk = 0, n_pass = 0;

   typedef struct {
      logic [7:0]  pm;
      logic        az;
      logic [10:0] exp;
   } vec_t;
   typedef struct packed {
      logic [10:0] exp;
      logic [7:0]  id;
   } sb_t;
   vec_t tbl [15];
   sb_t sb [$];
   sb_t e;

   instr_decoder #(.RESET_CYCLES(2), .FLUSH_ON_JUMP(1'b1)) dut (
      .clk(clk), .reset(reset), .pm_data(pm_data), .alu_zero(alu_zero),
      .sync_reset(sync_reset), .jmp(jmp), .jmp_nz(jmp_nz), .dont_jmp(dont_jmp),
      .jmp_addr(jmp_addr), .alu_en(alu_en), .load_en(load_en), .flush(flush)
   );

   instr_decoder #(.RESET_CYCLES(2), .FLUSH_ON_JUMP(1'b0)) dut_nf (
      .clk(clk), .reset(reset), .pm_data(pm_data), .alu_zero(alu_zero),
      .sync_reset(sync_reset_b), .jmp(jmp_b), .jmp_nz(jmp_nz_b), .dont_jmp(dont_jmp_b),
      .jmp_addr(jmp_addr_b), .alu_en(alu_en_b), .load_en(load_en_b), .flush(flush_b)
   );

   always #5 clk = ~clk;

   assign act = {sync_reset, jmp, jmp_nz, dont_jmp, flush, alu_en, load_en, jmp_addr};

   function automatic logic [10:0] o(input logic sr, j, jnz, dj, fl, alu, ld, input logic [3:0] addr);
      return {sr, j, jnz, dj, fl, alu, ld, addr};
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s got %h want %h", nm, got, want);
   endtask

   task automatic push(input logic [10:0] x, input int id);
      sb.push_back({x, 8'(id)});
   endtask

   task automatic run(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         @(posedge clk); #1;
         reset = 1'b1;
         pm_data = tbl[i].pm;
         alu_zero = tbl[i].az;
         push(tbl[i].exp, i);
      end
   endtask

   // combinational outputs are settled mid-cycle, well away from the rising edge
   always @(negedge clk)
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk($sformatf("vec%0d", e.id), 32'(act), 32'(e.exp));
      end

   initial begin
      tbl[0]  = '{8'hE5, 1'b0, o(1,0,0,0,0,0,0,4'h0)};
      tbl[1]  = '{8'hE5, 1'b0, o(1,0,0,0,0,0,0,4'h0)};
      tbl[2]  = '{8'hE5, 1'b0, o(0,1,0,0,0,0,0,4'h5)};
      tbl[3]  = '{8'hE5, 1'b0, o(0,0,0,0,1,0,0,4'h0)};
      tbl[4]  = '{8'hC0, 1'b1, o(0,0,0,0,0,1,0,4'h0)};
      tbl[5]  = '{8'hF3, 1'b0, o(0,0,1,1,0,0,0,4'h3)};
      tbl[6]  = '{8'hC0, 1'b0, o(0,0,0,1,0,1,0,4'h0)};
      tbl[7]  = '{8'hF3, 1'b0, o(0,0,1,0,0,0,0,4'h3)};
      tbl[8]  = '{8'hC0, 1'b1, o(0,0,0,0,1,0,0,4'h0)};
      tbl[9]  = '{8'hE1, 1'b0, o(0,1,0,0,0,0,0,4'h1)};
      tbl[10] = '{8'hE2, 1'b0, o(0,0,0,0,1,0,0,4'h0)};
      tbl[11] = '{8'h35, 1'b0, o(0,0,0,0,0,0,1,4'h0)};
      tbl[12] = '{8'h9A, 1'b0, o(0,0,0,0,0,0,1,4'h0)};
      tbl[13] = '{8'hD0, 1'b1, o(0,0,0,0,0,1,0,4'h0)};
      tbl[14] = '{8'hE7, 1'b0, o(0,1,0,1,0,0,0,4'h7)};
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_state", 32'(act), 32'(o(1,0,0,0,0,0,0,4'h0)));
      run(0, 14);
      @(posedge clk); #1;
      pm_data = 8'h00;
      alu_zero = 1'b0;
      @(negedge clk);
      chk("flush_with_z", {flush, dont_jmp}, 2'b11);
      #2 reset = 1'b0;
      #1 chk("mid_reset", {sync_reset, flush, dont_jmp, load_en}, 4'b1000);
      @(negedge clk);
      chk("held_in_reset", 32'(act), 32'(o(1,0,0,0,0,0,0,4'h0)));
      pm_data = 8'hE5;
      run(0, 2);
      @(posedge clk); #1;
      pm_data = 8'hE4;
      push(o(0,0,0,0,1,0,0,4'h0), 100);
      @(negedge clk);
      chk("nf_jmp", {jmp_b, jmp_addr_b, flush_b}, {1'b1, 4'h4, 1'b0});
      @(posedge clk); #1;
      pm_data = 8'hC0;
      push(o(0,0,0,0,0,1,0,4'h0), 101);
      @(negedge clk);
      chk("nf_alu", {alu_en_b, jmp_b, flush_b}, 3'b100);
      @(posedge clk); #1;
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
